// File: rtl/nic_cmd_responder_pkg.sv
// Shared command/completion types for the NIC-outbound command responder,
// plus the service-time helper used when a command is accepted.
package nic_cmd_responder_pkg;

  typedef logic [15:0] cmd_id_t;

  typedef struct packed {
    logic [31:0] length;
  } pspin_nic_cmd_t;

  typedef struct packed {
    pspin_nic_cmd_t nic_cmd;
  } pspin_cmd_descr_t;

  typedef struct packed {
    cmd_id_t          cmd_id;
    pspin_cmd_descr_t descr;
  } pspin_cmd_req_t;

  typedef struct packed {
    cmd_id_t     cmd_id;
    logic [31:0] status;
  } pspin_cmd_resp_t;

  // Service cycles = fixed_lat + ceil(length / 2^bpc_log2), saturated to 32 bits.
  // The 33-bit intermediate keeps the round-up of a near-max length from wrapping.
  function automatic logic [31:0] calc_svc(input logic [31:0] length,
                                           input int unsigned fixed_lat,
                                           input int unsigned bpc_log2);
    logic [32:0] round_up;
    logic [32:0] beats;
    logic [32:0] total;
    round_up = (33'd1 << bpc_log2) - 33'd1;
    beats    = ({1'b0, length} + round_up) >> bpc_log2;
    total    = beats + 33'(fixed_lat);
    return total[32] ? 32'hFFFF_FFFF : total[31:0];
  endfunction

endpackage

// File: rtl/nic_cmd_responder_if.sv
// Command request/completion bundle between the PsPIN command unit (master)
// and the NIC-side responder (slave).
interface nic_cmd_responder_if;
  import nic_cmd_responder_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  pspin_cmd_req_t  cmd;
  logic            resp_valid;
  pspin_cmd_resp_t resp;

  modport master (output cmd_valid, cmd, input cmd_ready, resp_valid, resp);
  modport slave  (input cmd_valid, cmd, output cmd_ready, resp_valid, resp);
endinterface

// File: rtl/nic_cmd_responder_fifo.sv
// Registered-output (non fall-through) FIFO holding accepted commands.
// DEPTH must be a power of two so the pointers wrap on their own.
module nic_cmd_responder_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     used_q;

  // Storage write on push.
  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  // NOTE: the storage array has no reset; only pointers and occupancy do, and slots
  // outside the occupied range are never read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr_q];
  assign full_o  = (used_q == (AW+1)'(DEPTH));
  assign empty_o = (used_q == '0);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $error("push into full command queue");
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
    else $error("pop from empty command queue");
endmodule

// File: rtl/nic_cmd_responder.sv
// NIC-outbound command responder: queues commands, serializes them one at a
// time for FIXED_LAT + ceil(length/BYTES_PER_CYCLE) cycles, then emits one
// completion per command in accept order.
module nic_cmd_responder
  import nic_cmd_responder_pkg::*;
#(
  parameter int unsigned NUM_OUTSTANDING = 8,
  parameter int unsigned FIXED_LAT       = 4,
  parameter int unsigned BYTES_PER_CYCLE = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  nic_cmd_responder_if.slave   cmd_if,
  output logic                 busy_o,
  output logic [31:0]          cmd_count_o
);
  localparam int unsigned BPC_LOG2 = $clog2(BYTES_PER_CYCLE);

  typedef struct packed {
    cmd_id_t     cmd_id;
    logic [31:0] svc;
  } q_entry_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  q_entry_t        q_in, q_out;
  logic            q_push, q_pop, q_full, q_empty;
  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  cmd_id_t         id_q, id_d;
  logic [31:0]     count_q, count_d;
  logic            rdy_q;
  pspin_cmd_resp_t resp;

  // Ready comes from registered state only, so a full queue stays not-ready
  // even in a cycle where the head is being popped.
  assign cmd_if.cmd_ready = rdy_q & ~q_full;
  assign q_push           = cmd_if.cmd_valid & cmd_if.cmd_ready;
  assign q_in             = '{cmd_id: cmd_if.cmd.cmd_id,
                              svc:    calc_svc(cmd_if.cmd.descr.nic_cmd.length, FIXED_LAT, BPC_LOG2)};

  nic_cmd_responder_fifo #(
    .DEPTH (NUM_OUTSTANDING),
    .T     (q_entry_t)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .data_i  (q_in),
    .data_o  (q_out),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Next-state logic: pop and load in IDLE/RESP, count down in BUSY.
  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    count_d = count_q;
    q_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          id_d    = q_out.cmd_id;
          cnt_d   = q_out.svc - 32'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
        else                state_d = RESP;
      end
      RESP: begin
        count_d = count_q + 32'd1;
        if (!q_empty) begin
          q_pop   = 1'b1;
          id_d    = q_out.cmd_id;
          cnt_d   = q_out.svc - 32'd1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, service counter, in-service id and completion counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      count_q <= count_d;
      rdy_q   <= 1'b1;
    end
  end

  // Completion word: echoed id during RESP, all zero otherwise.
  always_comb begin
    resp = '0;
    if (state_q == RESP) resp.cmd_id = id_q;
  end

  assign cmd_if.resp       = resp;
  assign cmd_if.resp_valid = (state_q == RESP);
  assign busy_o            = ~q_empty | (state_q != IDLE);
  assign cmd_count_o       = count_q;

  a_cmd_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cmd_if.cmd_valid && !cmd_if.cmd_ready) |=> (!cmd_if.cmd_valid || $stable(cmd_if.cmd)))
    else $error("command changed while stalled");
  a_resp_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cmd_if.resp_valid |-> (state_q == RESP))
    else $error("completion outside RESP");
endmodule
